// File: rtl/vga_num_writer.sv
// vga_num_writer
// Converts a signed 32-bit integer to decimal with a sequential
// double-dabble engine, then writes the 14 GPIO display registers
// (12 digits, decimal point, sign) in a back-to-back burst. Outside the
// burst the CPU's GPIO bus is passed straight through; during the burst
// the engine owns the bus and any CPU access is stalled.
module vga_num_writer #(
    parameter logic [31:0] BASE  = 32'h0000_0000,
    parameter logic [7:0]  BLANK = 8'h0F,
    parameter logic [7:0]  NEG   = 8'h01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] value,
    input  logic [7:0]  point_pos,
    output logic        busy,
    output logic        done,
    input  logic        cpu_req,
    input  logic        cpu_wr_en,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_dat,
    output logic        cpu_stall,
    output logic        bus_wr_en,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_dat
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CONV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Last conversion iteration and last register index of the burst.
    localparam logic [5:0] CONV_LAST  = 6'd31;
    localparam logic [3:0] WRITE_LAST = 4'd13;

    state_t      r_state;
    state_t      w_next_state;

    logic [5:0]  r_cnt;     // double-dabble iteration counter
    logic [3:0]  r_k;       // register index within the burst
    logic [39:0] r_bcd;     // 10 BCD digits, digit 0 in bits [3:0]
    logic [31:0] r_mag;     // magnitude being shifted into the BCD register
    logic        r_neg;     // sign of the latched value
    logic [7:0]  r_point;   // latched decimal-point position

    logic [39:0] w_bcd_adj;
    logic [3:0]  w_msd;
    logic [3:0]  w_keep;
    logic [39:0] w_bcd_shift;
    logic [3:0]  w_nib;
    logic [7:0]  w_code;

    // Add 3 to every BCD nibble that is 5 or more, ahead of the shift.
    function automatic logic [39:0] bcd_adjust(input logic [39:0] b);
        logic [39:0] res;
        logic [3:0]  nib;
        res = b;
        for (int i = 0; i < 10; i++) begin
            nib = b[4*i +: 4];
            if (nib >= 4'd5) begin
                res[4*i +: 4] = nib + 4'd3;
            end else begin
                res[4*i +: 4] = nib;
            end
        end
        return res;
    endfunction

    // Index of the highest nonzero BCD digit; 0 when the whole value is 0.
    function automatic logic [3:0] find_msd(input logic [39:0] b);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (b[4*i +: 4] != 4'd0) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; start is only honoured in IDLE and never queued.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_CONV;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_CONV: begin
                if (r_cnt == CONV_LAST) begin
                    w_next_state = S_WRITE;
                end else begin
                    w_next_state = S_CONV;
                end
            end
            S_WRITE: begin
                if (r_k == WRITE_LAST) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_WRITE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, double-dabble iterations, burst index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= 6'd0;
            r_k     <= 4'd0;
            r_bcd   <= 40'd0;
            r_mag   <= 32'd0;
            r_neg   <= 1'b0;
            r_point <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        // Negating 32'h80000000 yields itself, which read as
                        // unsigned is exactly 2147483648.
                        r_neg   <= value[31];
                        r_mag   <= value[31] ? (32'd0 - value) : value;
                        r_point <= point_pos;
                        r_bcd   <= 40'd0;
                        r_cnt   <= 6'd0;
                        r_k     <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt;
                    end
                end
                S_CONV: begin
                    r_bcd <= {w_bcd_adj[38:0], r_mag[31]};
                    r_mag <= {r_mag[30:0], 1'b0};
                    if (r_cnt == CONV_LAST) begin
                        r_cnt <= 6'd0;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                S_WRITE: begin
                    if (r_k == WRITE_LAST) begin
                        r_k <= 4'd0;
                    end else begin
                        r_k <= r_k + 4'd1;
                    end
                end
                S_DONE: begin
                    r_k <= 4'd0;
                end
                default: begin
                    r_cnt <= 6'd0;
                    r_k   <= 4'd0;
                end
            endcase
        end
    end

    assign w_bcd_adj = bcd_adjust(r_bcd);

    // Blanking: keep digits up to the most significant one, extended to the
    // decimal point when the point lands on a displayable digit.
    always_comb begin
        w_msd = find_msd(r_bcd);
        if ((r_point < 8'd12) && (r_point[3:0] > w_msd)) begin
            w_keep = r_point[3:0];
        end else begin
            w_keep = w_msd;
        end
    end

    assign w_bcd_shift = r_bcd >> {r_k, 2'b00};
    assign w_nib       = w_bcd_shift[3:0];

    // Code written to register k of the burst.
    always_comb begin
        w_code = BLANK;
        if (r_k < 4'd10) begin
            if (r_k <= w_keep) begin
                w_code = {4'h0, w_nib};
            end else begin
                w_code = BLANK;
            end
        end else if (r_k < 4'd12) begin
            // The two top digits have no BCD source; they show zero only when
            // the point forces them into the kept range.
            if (w_keep >= 4'd10) begin
                w_code = 8'h00;
            end else begin
                w_code = BLANK;
            end
        end else if (r_k == 4'd12) begin
            w_code = r_point;
        end else begin
            w_code = r_neg ? NEG : 8'h00;
        end
    end

    // Outputs: status decode and the CPU/engine bus multiplexer.
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        cpu_stall = 1'b0;
        bus_wr_en = cpu_wr_en;
        bus_addr  = cpu_addr;
        bus_dat   = cpu_dat;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_CONV: begin
                busy = 1'b1;
            end
            S_WRITE: begin
                busy      = 1'b1;
                cpu_stall = cpu_req;
                bus_wr_en = 1'b1;
                bus_addr  = BASE + {28'h0, r_k};
                bus_dat   = {24'h0, w_code};
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_vga_num_writer.sv
// Testbench for vga_num_writer: expected register writes are computed by
// plain integer division and queued at start; a negedge monitor pops and
// compares them as the burst appears on the bus.
module tb_vga_num_writer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] value;
    logic [7:0]  point_pos;
    logic        busy;
    logic        done;
    logic        cpu_req;
    logic        cpu_wr_en;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_dat;
    logic        cpu_stall;
    logic        bus_wr_en;
    logic [31:0] bus_addr;
    logic [31:0] bus_dat;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] dat;
    } wr_t;

    wr_t sb[$];
    int  n_total = 0;
    int  n_bad   = 0;

    vga_num_writer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .value     (value),
        .point_pos (point_pos),
        .busy      (busy),
        .done      (done),
        .cpu_req   (cpu_req),
        .cpu_wr_en (cpu_wr_en),
        .cpu_addr  (cpu_addr),
        .cpu_dat   (cpu_dat),
        .cpu_stall (cpu_stall),
        .bus_wr_en (bus_wr_en),
        .bus_addr  (bus_addr),
        .bus_dat   (bus_dat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: decimal digits by division, then the blanking rules.
    task automatic push_exp(input logic [31:0] v, input logic [7:0] pp);
        logic            neg;
        logic [31:0]     mag;
        longint unsigned m;
        int              d[10];
        int              msd;
        int              keep;
        logic [7:0]      code;
        wr_t             w;
        neg = v[31];
        mag = neg ? (32'd0 - v) : v;
        m   = 64'(mag);
        msd = 0;
        for (int i = 0; i < 10; i++) begin
            d[i] = int'(m % 64'd10);
            m    = m / 64'd10;
            if (d[i] != 0) msd = i;
        end
        keep = msd;
        if ((pp < 8'd12) && (int'(pp) > msd)) keep = int'(pp);
        for (int k = 0; k < 14; k++) begin
            if (k < 10)       code = (k <= keep) ? 8'(d[k]) : 8'h0F;
            else if (k < 12)  code = (keep >= 10) ? 8'h00 : 8'h0F;
            else if (k == 12) code = pp;
            else              code = neg ? 8'h01 : 8'h00;
            w.addr = 32'(k);
            w.dat  = {24'h0, code};
            sb.push_back(w);
        end
    endtask

    // Scoreboard monitor: every engine write during the burst is compared.
    always @(negedge clk) begin
        if (rst_n && busy && !done && bus_wr_en) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_wr", 64'(bus_addr), 64'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("wr_addr", 64'(bus_addr), 64'(e.addr));
                chk("wr_dat", 64'(bus_dat), 64'(e.dat));
            end
        end
    end

    // Issue start and wait for done; checks latency and the return to idle.
    task automatic run_num(input logic [31:0] v, input logic [7:0] pp);
        int n;
        bit got;
        push_exp(v, pp);
        @(posedge clk); #1;
        value = v; point_pos = pp; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        value = $urandom; point_pos = 8'($urandom);
        n = 0; got = 1'b0;
        while (n < 60 && !got) begin
            @(negedge clk);
            n++;
            if (n == 1) chk("busy_rise", 64'(busy), 64'd1);
            if (done) got = 1'b1;
        end
        if (got) chk("done_latency", 64'(n), 64'd47);
        else     chk("done_timeout", 64'd0, 64'd1);
        @(negedge clk);
        chk("busy_fall", 64'(busy), 64'd0);
        chk("sb_drained", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst_n = 1'b0; start = 1'b0; value = 32'd0; point_pos = 8'd0;
        cpu_req = 1'b1; cpu_wr_en = 1'b1; cpu_addr = 32'd5; cpu_dat = 32'd7;
        #3;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_stall", 64'(cpu_stall), 64'd0);
        chk("rst_bus_wr", 64'(bus_wr_en), 64'd1);
        chk("rst_bus_addr", 64'(bus_addr), 64'd5);
        chk("rst_bus_dat", 64'(bus_dat), 64'd7);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_pass_addr", 64'(bus_addr), 64'd5);
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_wr_en = 1'b0; cpu_addr = 32'd0; cpu_dat = 32'd0;

        run_num(32'd1234, 8'hFF);
        run_num(-32'sd5, 8'd2);
        run_num(32'h8000_0000, 8'hFF);
        run_num(32'd0, 8'hFF);
        run_num(32'd7, 8'd11);
        run_num(32'd2147483647, 8'd12);
        run_num(32'd999999999, 8'd0);

        // CPU access during the burst, plus an ignored second start.
        push_exp(32'd42, 8'hFF);
        @(posedge clk); #1;
        value = 32'd42; point_pos = 8'hFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 47; c++) begin
            if (c == 10) start = 1'b1;
            if (c == 11) start = 1'b0;
            if (c == 35) begin
                cpu_req = 1'b1; cpu_wr_en = 1'b1; cpu_addr = 32'd20; cpu_dat = 32'd99;
            end
            @(negedge clk);
            if (c == 35) begin
                chk("stall_on", 64'(cpu_stall), 64'd1);
                chk("stall_bus_addr", 64'(bus_addr), 64'd2);
            end
            if (c == 46) chk("stall_last", 64'(cpu_stall), 64'd1);
            if (c == 47) begin
                chk("done_at_47", 64'(done), 64'd1);
                chk("stall_off", 64'(cpu_stall), 64'd0);
                chk("cpu_wr_en_out", 64'(bus_wr_en), 64'd1);
                chk("cpu_addr_out", 64'(bus_addr), 64'd20);
                chk("cpu_dat_out", 64'(bus_dat), 64'd99);
            end
            @(posedge clk); #1;
            if (c == 47) begin
                cpu_req = 1'b0; cpu_wr_en = 1'b0; cpu_addr = 32'd0; cpu_dat = 32'd0;
            end
        end
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy) cnt++;
        end
        chk("second_start_ignored", 64'(cnt), 64'd0);
        chk("sb_drained_cpu", 64'(sb.size()), 64'd0);

        // Reset in the middle of the burst.
        push_exp(32'd777, 8'hFF);
        @(posedge clk); #1;
        value = 32'd777; point_pos = 8'hFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 39; c++) begin
            @(posedge clk); #1;
        end
        chk("pre_rst_remaining", 64'(sb.size()), 64'd7);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_wr", 64'(bus_wr_en), 64'd0);
        sb.delete();
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus_wr_en) cnt++;
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (bus_wr_en || busy) cnt++;
        end
        chk("rst_no_writes", 64'(cnt), 64'd0);
        run_num(-32'sd123456789, 8'd3);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_num_writer.md
# vga_num_writer

Sequencer that owns the write side of the GPIO display register bank. On a start pulse it converts a signed 32-bit integer to decimal (sequential double-dabble) and then writes all 14 display registers (12 digits, decimal point, sign) in 14 consecutive bus cycles. While idle or converting, it passes the CPU's GPIO bus straight through. During the write burst it owns the bus and stalls any CPU access. It sits between the CPU bus master and the GPIO block.

## Interface
- `BASE`, 32'h0: GPIO base address. Digit i is at `BASE+i`, point at `BASE+12`, sign at `BASE+13`.
- `BLANK`, 8'h0F: code written to a blanked digit.
- `NEG`, 8'h01: sign register code for a negative value. A positive value writes 8'h00.
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `start`, in, 1: one-cycle request. Accepted only in IDLE.
- `value`, in, 32: two's-complement number, sampled when `start` is accepted.
- `point_pos`, in, 8: decimal-point digit index, sampled with `value`. 8'hFF means no point.
- `busy`, out, 1: high while state != IDLE.
- `done`, out, 1: one-cycle pulse when the burst completes.
- `cpu_req`, in, 1: CPU has a GPIO access (read or write) this cycle.
- `cpu_wr_en`, in, 1: CPU write enable.
- `cpu_addr`, in, 32: CPU address.
- `cpu_dat`, in, 32: CPU write data.
- `cpu_stall`, out, 1: CPU must hold its access. Equals `cpu_req` while in WRITE.
- `bus_wr_en`, out, 1: GPIO write enable.
- `bus_addr`, out, 32: GPIO address.
- `bus_dat`, out, 32: GPIO write data.

## Operation
- The FSM has four states: IDLE, CONV, WRITE, DONE.
- IDLE:
  - `start`=1 latches the following, then goes to CONV: `neg=value[31]`, `mag = neg ? -value : value` (32-bit unsigned; 32'h80000000 gives 2147483648), `point_pos`.
  - `start` in any other state is ignored and not queued.
- CONV: 32 double-dabble iterations on a 40-bit BCD register (10 digits).
  - Each cycle: add 3 to every BCD nibble ≥5, then shift `{bcd,mag}` left by 1.
  - A 6-bit counter runs 0..31. On 31, go to WRITE.
- Blanking, evaluated on the final BCD value:
  - Let `msd` = index of the highest nonzero digit (0 if value is 0).
  - Let `keep = max(msd, point_pos)` if `point_pos` < 12, else `msd`.
  - Digit i gets BCD nibble i (zero-extended to 8 bits) for i ≤ keep and i < 10. Otherwise it gets `BLANK`.
  - Digits 10 and 11 are always `BLANK` unless `keep` ≥ 10, in which case they are 8'h00.
- WRITE: a 4-bit index k runs 0..13, one write per cycle.
  - Each cycle drives `bus_wr_en`=1 and `bus_addr`=`BASE+k`.
  - `bus_dat` = {24'b0, code_k}. Code for k 0..11 is the digit; for k=12 it is `point_pos`; for k=13 it is `neg ? NEG : 8'h00`.
  - On k=13, go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Bus mux (combinational):
  - In WRITE, the bus carries the engine's values.
  - In any other state, `bus_wr_en`/`bus_addr`/`bus_dat` = `cpu_wr_en`/`cpu_addr`/`cpu_dat`.
- `cpu_stall` = (state==WRITE) & `cpu_req`.
  - The CPU write is suppressed and the CPU address is not driven onto the bus.
  - The stalled access completes on the first cycle after WRITE exits.

## Timing
- Reset values:
  - State IDLE; all counters, BCD, `mag`, `neg` and latched point cleared.
  - `busy`=0, `done`=0, `cpu_stall`=0.
  - Bus outputs follow CPU inputs.
- `start` accepted at edge t:
  - `busy`=1 from t+1.
  - CONV occupies cycles t+1..t+32.
  - WRITE occupies t+33..t+46.
  - DONE is cycle t+47.
  - IDLE from t+48, where `busy`=0.
- A new start is accepted at the t+48 edge at the earliest. Total latency is 47 cycles start-to-done.
- CPU passthrough is zero latency (combinational) in IDLE, CONV and DONE.
- Reset asserted mid-CONV or mid-WRITE:
  - Immediate return to IDLE and the burst is abandoned.
  - Registers already written in the GPIO keep their values.
- `value`/`point_pos` changing after acceptance has no effect.

## Test plan
- **After reset:** `cpu_req`=1, `cpu_wr_en`=1, `cpu_addr`=5, `cpu_dat`=7 -> bus shows wr_en 1, addr 5, dat 7; `busy`=0, `cpu_stall`=0.
- **Value 1234, `point_pos`=FF:**
  - Writes at addr 0..13: 4,3,2,1, then `BLANK`×8, then FF, then 00.
  - `done` pulses exactly 47 cycles after start.
- **Value -5, `point_pos`=2:**
  - Digits 5,0,0, then `BLANK`×9, then point 02, then sign `NEG`.
- **Value 32'h80000000:**
  - Digits 8,4,6,3,8,4,7,4,1,2, then `BLANK`,`BLANK`, then FF, then 01.
- **CPU write asserted at cycle t+35 (inside WRITE):**
  - `cpu_stall`=1 through t+46 and the bus carries engine values.
  - The CPU write appears on the bus at t+47.
  - A second `start` pulsed during `busy` is ignored.
- **`rst_n` low at cycle t+40:**
  - `busy`=0 immediately and no further bus writes occur.
  - A new start after reset completes normally with correct values.
